// File: rtl/pspin_pkg.sv
// Shared PsPIN definitions: DMA tag field layout and the default execution context.
// The HER generator decodes tags with the same constants.
package pspin_pkg;

    localparam int TAG_CTX_LSB   = 0;
    localparam int TAG_CTX_W     = 2;
    localparam int TAG_EOM_LSB   = TAG_CTX_LSB + TAG_CTX_W;
    localparam int TAG_MSGID_LSB = TAG_EOM_LSB + 1;
    localparam int TAG_MSGID_W   = 10;
    localparam int TAG_USED_W    = TAG_MSGID_LSB + TAG_MSGID_W;

    localparam logic [TAG_CTX_W-1:0] DEFAULT_CTX_ID = 2'd0;

    function automatic logic is_pow2(input longint unsigned v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/pspin_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit plus an any-set flag.
module pspin_prio_enc #(
    parameter int N  = 64,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [N-1:0] w_lowest;

    // Isolate the lowest set bit, then OR-encode the one-hot result.
    always_comb begin
        w_lowest = i_vec & (~i_vec + {{(N-1){1'b0}}, 1'b1});
        o_any    = |i_vec;
        o_idx    = '0;
        for (int i = 0; i < N; i++) begin
            o_idx = o_idx | (w_lowest[i] ? IW'(i) : {IW{1'b0}});
        end
    end

endmodule

// File: rtl/pspin_pkt_alloc.sv
// Packet buffer slot allocator feeding the ingress DMA: claims the lowest free
// L2 slot per matched descriptor and releases slots on handler feedback.
module pspin_pkt_alloc
    import pspin_pkg::*;
#(
    parameter int C_MSGID_WIDTH  = 10,
    parameter int CTX_ID_WIDTH   = 2,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 20,
    parameter int TAG_WIDTH      = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF_START = 32'h0,
    parameter int SLOT_SIZE      = 2048,
    parameter int NUM_SLOTS      = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        match_valid,
    output logic                        match_ready,
    input  logic [C_MSGID_WIDTH-1:0]    match_msgid,
    input  logic                        match_is_eom,
    input  logic [CTX_ID_WIDTH-1:0]     match_ctx_id,
    input  logic [LEN_WIDTH-1:0]        match_len,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    output logic [LEN_WIDTH-1:0]        cmd_len,
    output logic [TAG_WIDTH-1:0]        cmd_tag,
    input  logic                        free_valid,
    output logic                        free_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   free_addr,
    output logic [$clog2(NUM_SLOTS):0]  occupancy,
    output logic [31:0]                 alloc_cnt,
    output logic [31:0]                 drop_cnt,
    output logic [31:0]                 free_err_cnt
);

    localparam int IDX_W      = $clog2(NUM_SLOTS);
    localparam int OCC_W      = IDX_W + 1;
    localparam int SLOT_SHIFT = $clog2(SLOT_SIZE);
    localparam int EOM_LSB    = TAG_CTX_LSB + CTX_ID_WIDTH;
    localparam int MSGID_LSB  = EOM_LSB + 1;
    localparam logic [AXI_ADDR_WIDTH:0] REGION_BYTES =
        (AXI_ADDR_WIDTH+1)'(longint'(NUM_SLOTS) * longint'(SLOT_SIZE));
    localparam logic [LEN_WIDTH-1:0] SLOT_LEN = LEN_WIDTH'(SLOT_SIZE);

    if (TAG_WIDTH < C_MSGID_WIDTH + 1 + CTX_ID_WIDTH) begin : g_bad_tag
        $error("TAG_WIDTH too small for {msgid, is_eom, ctx_id}");
    end
    if (!is_pow2(64'(SLOT_SIZE))) begin : g_bad_slot
        $error("SLOT_SIZE must be a power of two");
    end
    if (!is_pow2(64'(NUM_SLOTS)) || NUM_SLOTS < 2) begin : g_bad_num
        $error("NUM_SLOTS must be a power of two >= 2");
    end

    logic [NUM_SLOTS-1:0]      r_busy;
    logic                      r_cmd_valid;
    logic [AXI_ADDR_WIDTH-1:0] r_cmd_addr;
    logic [LEN_WIDTH-1:0]      r_cmd_len;
    logic [TAG_WIDTH-1:0]      r_cmd_tag;
    logic [OCC_W-1:0]          r_occupancy;
    logic [31:0]               r_alloc_cnt;
    logic [31:0]               r_drop_cnt;
    logic [31:0]               r_free_err_cnt;

    logic [NUM_SLOTS-1:0]      w_free_vec;
    logic [IDX_W-1:0]          w_alloc_idx;
    logic                      w_any_free;
    logic                      w_slot_open;
    logic                      w_oversize;
    logic                      w_accept;
    logic                      w_alloc;
    logic                      w_drop;
    logic [AXI_ADDR_WIDTH-1:0] w_free_off;
    logic                      w_in_range;
    logic [IDX_W-1:0]          w_free_idx;
    logic                      w_free_ok;
    logic                      w_free_err;
    logic [NUM_SLOTS-1:0]      w_alloc_mask;
    logic [NUM_SLOTS-1:0]      w_free_mask;
    logic [OCC_W-1:0]          w_occ_next;
    logic [TAG_WIDTH-1:0]      w_tag;

    assign w_free_vec = ~r_busy;

    pspin_prio_enc #(.N(NUM_SLOTS), .IW(IDX_W)) u_prio_enc (
        .i_vec (w_free_vec),
        .o_idx (w_alloc_idx),
        .o_any (w_any_free)
    );

    // Handshake decode, free-address validation and bitmap update masks.
    always_comb begin
        w_slot_open = !r_cmd_valid || cmd_ready;
        w_oversize  = (match_len == '0) || (match_len > SLOT_LEN);
        match_ready = w_slot_open && (w_any_free || w_oversize);
        w_accept    = match_valid && match_ready;
        w_alloc     = w_accept && !w_oversize;
        w_drop      = w_accept && w_oversize;

        // Offset compare avoids overflow when the region ends at the top of the map.
        w_free_off  = free_addr - BUF_START;
        w_in_range  = (free_addr >= BUF_START) && ({1'b0, w_free_off} < REGION_BYTES);
        w_free_idx  = IDX_W'(w_free_off >> SLOT_SHIFT);
        w_free_ok   = free_valid && w_in_range && r_busy[w_free_idx];
        w_free_err  = free_valid && !w_free_ok;

        w_alloc_mask = NUM_SLOTS'(w_alloc) << w_alloc_idx;
        w_free_mask  = NUM_SLOTS'(w_free_ok) << w_free_idx;

        w_tag = '0;
        w_tag[TAG_CTX_LSB +: CTX_ID_WIDTH] = match_ctx_id;
        w_tag[EOM_LSB]                     = match_is_eom;
        w_tag[MSGID_LSB +: C_MSGID_WIDTH]  = match_msgid;

        case ({w_alloc, w_free_ok})
            2'b10:   w_occ_next = r_occupancy + {{(OCC_W-1){1'b0}}, 1'b1};
            2'b01:   w_occ_next = r_occupancy - {{(OCC_W-1){1'b0}}, 1'b1};
            default: w_occ_next = r_occupancy;
        endcase
    end

    // Bitmap, command stage and event counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_busy         <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_addr     <= '0;
            r_cmd_len      <= '0;
            r_cmd_tag      <= '0;
            r_occupancy    <= '0;
            r_alloc_cnt    <= 32'd0;
            r_drop_cnt     <= 32'd0;
            r_free_err_cnt <= 32'd0;
        end else begin
            r_busy      <= (r_busy | w_alloc_mask) & ~w_free_mask;
            r_occupancy <= w_occ_next;
            if (w_alloc) begin
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= BUF_START + (AXI_ADDR_WIDTH'(w_alloc_idx) << SLOT_SHIFT);
                r_cmd_len   <= match_len;
                r_cmd_tag   <= w_tag;
                r_alloc_cnt <= r_alloc_cnt + 32'd1;
            end else if (cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end else begin
                r_cmd_valid <= r_cmd_valid;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
            if (w_free_err) begin
                r_free_err_cnt <= r_free_err_cnt + 32'd1;
            end else begin
                r_free_err_cnt <= r_free_err_cnt;
            end
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_addr     = r_cmd_addr;
    assign cmd_len      = r_cmd_len;
    assign cmd_tag      = r_cmd_tag;
    assign free_ready   = 1'b1;
    assign occupancy    = r_occupancy;
    assign alloc_cnt    = r_alloc_cnt;
    assign drop_cnt     = r_drop_cnt;
    assign free_err_cnt = r_free_err_cnt;

endmodule
